multi_timer_core: RTL

- N-channel, parametrised-width successor of the single-channel timer core; sits behind the timer register block on the divided clock domain.
- Each channel counts to a per-channel period and raises a sticky interrupt.
- Period is double-buffered (shadow reload at terminal count); a one-shot channel halts in DONE until cleared.
- Per-channel IRQ vector plus an OR-reduced summary IRQ feed the interrupt controller.

---
 rtl/timer_pkg.sv | 13 +
 rtl/multi_timer_core_if.sv | 39 +++
 rtl/timer_channel.sv | 124 ++++++++++++
 rtl/multi_timer_core.sv | 50 +++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: FSM encoding and default width.
// Build option TIMER_PWM_EN adds per-channel duty inputs and registered PWM outputs.
package timer_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/multi_timer_core_if.sv
// Control/status bundle between the timer register block and multi_timer_core.
// With TIMER_PWM_EN defined the bundle also carries i_duty and o_pwm.
interface multi_timer_core_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = timer_pkg::CNT_W_DEFAULT
);
  // No valid/ready here: every input is a level the core samples on each
  // clock edge, and every output is a register refreshed on each edge.
  logic [N_CH-1:0]       i_en;
  logic [N_CH-1:0]       i_cont;
  logic [N_CH-1:0]       i_irq_clear;
  logic [N_CH*CNT_W-1:0] i_period;
  logic [N_CH-1:0]       o_irq;
  logic                  o_irq_any;
  logic [N_CH*CNT_W-1:0] o_count;
  logic [2*N_CH-1:0]     o_state;
`ifdef TIMER_PWM_EN
  logic [N_CH*CNT_W-1:0] i_duty;
  logic [N_CH-1:0]       o_pwm;

  modport master (
    output i_en, i_cont, i_irq_clear, i_period, i_duty,
    input  o_irq, o_irq_any, o_count, o_state, o_pwm
  );
  modport slave (
    input  i_en, i_cont, i_irq_clear, i_period, i_duty,
    output o_irq, o_irq_any, o_count, o_state, o_pwm
  );
`else
  modport master (
    output i_en, i_cont, i_irq_clear, i_period,
    input  o_irq, o_irq_any, o_count, o_state
  );
  modport slave (
    input  i_en, i_cont, i_irq_clear, i_period,
    output o_irq, o_irq_any, o_count, o_state
  );
`endif
endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, counter, double-buffered period,
// sticky IRQ; with TIMER_PWM_EN also a duty shadow and registered PWM output.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_cont,
  input  logic             i_irq_clear,
  input  logic [CNT_W-1:0] i_period,
`ifdef TIMER_PWM_EN
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_pwm,
`endif
  output logic [CNT_W-1:0] o_count,
  output logic             o_irq,
  output logic             o_irq_next,
  output timer_state_e     o_state
);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             irq_q, irq_d;
  logic             terminal;
`ifdef TIMER_PWM_EN
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
`endif

  assign terminal = (count_q == shadow_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      irq_q    <= 1'b0;
`ifdef TIMER_PWM_EN
      duty_q   <= '0;
      pwm_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      irq_q    <= irq_d;
`ifdef TIMER_PWM_EN
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    irq_d    = irq_q;
`ifdef TIMER_PWM_EN
    duty_d   = duty_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        count_d  = '0;
        irq_d    = 1'b0;
        shadow_d = i_period;
`ifdef TIMER_PWM_EN
        duty_d   = i_duty;
`endif
        if (i_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!i_en) begin
          state_d = ST_IDLE;
          count_d = '0;
          irq_d   = 1'b0;
        end else if (terminal) begin
          // Set beats a simultaneous clear so no terminal event is lost.
          count_d  = '0;
          irq_d    = 1'b1;
          shadow_d = i_period;
`ifdef TIMER_PWM_EN
          duty_d   = i_duty;
`endif
          if (!i_cont) state_d = ST_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (i_irq_clear) irq_d = 1'b0;
        end
      end
      ST_DONE: begin
        count_d = '0;
        if (!i_en) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end else if (i_irq_clear) begin
          state_d = ST_RUN;
          irq_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        irq_d   = 1'b0;
      end
    endcase
  end

`ifdef TIMER_PWM_EN
  // Computed from next-state values so the register lines up with o_count.
  assign pwm_d = (state_d == ST_RUN) && (count_d < duty_d);
  assign o_pwm = pwm_q;
`endif

  assign o_count    = count_q;
  assign o_irq      = irq_q;
  assign o_irq_next = irq_d;
  assign o_state    = state_q;

endmodule

// File: rtl/multi_timer_core.sv
// N-channel timer core: slices the flat buses into timer_channel instances and
// registers the OR of the channel IRQs. Optional PWM via TIMER_PWM_EN.
module multi_timer_core
  import timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic               i_clk,
  input logic               i_rst,
  multi_timer_core_if.slave bus
);

  logic [N_CH-1:0] irq_next;
  logic            irq_any_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    timer_state_e st;

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (bus.i_en[k]),
      .i_cont      (bus.i_cont[k]),
      .i_irq_clear (bus.i_irq_clear[k]),
      .i_period    (bus.i_period[k*CNT_W +: CNT_W]),
`ifdef TIMER_PWM_EN
      .i_duty      (bus.i_duty[k*CNT_W +: CNT_W]),
      .o_pwm       (bus.o_pwm[k]),
`endif
      .o_count     (bus.o_count[k*CNT_W +: CNT_W]),
      .o_irq       (bus.o_irq[k]),
      .o_irq_next  (irq_next[k]),
      .o_state     (st)
    );

    assign bus.o_state[2*k +: 2] = st;
  end

  // Built from the next-state vector so the summary moves with o_irq.
  always_ff @(posedge i_clk) begin
    if (i_rst) irq_any_q <= 1'b0;
    else       irq_any_q <= |irq_next;
  end

  assign bus.o_irq_any = irq_any_q;

endmodule
